// File: rtl/fa32_arbiter_if.sv
// fa32_arbiter_if: requester and response bundle for fa32_arbiter
interface fa32_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ-1:0]    req_lock;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_sum;
    logic               rsp_cout;
    logic [IDW-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_lock, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_lock, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
    );
endinterface

// File: rtl/fa32_arbiter.sv
// fa32_arbiter: round-robin sharing of one 32-bit adder; define FA32_ARB_LOCK_EN for locked multi-word carry chaining
module fa32_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic           clk,
    input logic           rst,
    fa32_arbiter_if.slave bus
);
`ifdef FA32_ARB_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;
    state_t         state;
    logic           chain_c;
    logic [IDW-1:0] lock_id;
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
`endif
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  nxt;
    logic [IDW:0]    idx;
    logic            any;
    logic            out_free;
    logic            xfer;
    logic            cin;
    logic            cout;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     sum;
    logic [NREQ-1:0] ready;
    logic            valid_r;
    logic [31:0]     sum_r;
    logic            cout_r;
    logic [IDW-1:0]  id_r;

    // Winner: first valid requester at or after ptr, or the lock owner while locked
    always_comb begin
        win = ptr;
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(NREQ))
                idx = idx - (IDW + 1)'(NREQ);
            if (bus.req_valid[idx[IDW-1:0]]) begin
                win = idx[IDW-1:0];
                any = 1'b1;
            end
        end
`ifdef FA32_ARB_LOCK_EN
        if (state == LOCKED) begin
            win = lock_id;
            any = bus.req_valid[lock_id];
        end
`endif
    end

    assign out_free = !valid_r || bus.rsp_ready;
    assign ready    = (out_free && any && !rst) ? NREQ'(1) << win : '0;
    assign xfer     = |ready;
    assign nxt      = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign a        = bus.req_a[{win, 5'd0} +: 32];
    assign b        = bus.req_b[{win, 5'd0} +: 32];
`ifdef FA32_ARB_LOCK_EN
    assign cin      = (state == LOCKED) ? chain_c : bus.req_cin[win];
`else
    assign cin      = bus.req_cin[win];
`endif
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + 33'(cin);

    // Result register, round-robin pointer and lock state advance on each transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            id_r    <= '0;
            ptr     <= '0;
`ifdef FA32_ARB_LOCK_EN
            state   <= ARB;
            chain_c <= 1'b0;
            lock_id <= '0;
`endif
        end else if (xfer) begin
            valid_r <= 1'b1;
            sum_r   <= sum;
            cout_r  <= cout;
            id_r    <= win;
            ptr     <= nxt;
`ifdef FA32_ARB_LOCK_EN
            chain_c <= cout;
            lock_id <= win;
            state   <= bus.req_lock[win] ? LOCKED : ARB;
`endif
        end else if (bus.rsp_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_sum   = sum_r;
    assign bus.rsp_cout  = cout_r;
    assign bus.rsp_id    = id_r;
endmodule

// File: tb/tb_fa32_arbiter.sv
// tb_fa32_arbiter: directed vector table plus fairness, lock and reset sequences
module tb_fa32_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   counts [4];

    fa32_arbiter_if bus ();
    fa32_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  cin;
        logic        rr;
        logic [3:0]  exp_ready;
        logic        exp_v;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cin, input logic [3:0] lock);
        bus.req_valid = valid;
        bus.req_a     = {4{a}};
        bus.req_b     = {4{b}};
        bus.req_cin   = cin;
        bus.req_lock  = lock;
    endtask

    task automatic slot(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge
    task automatic step(input string tag, input logic [3:0] exp_ready, input logic exp_v,
                        input logic [31:0] exp_sum, input logic exp_cout, input logic [1:0] exp_id);
        #1;
        check({tag, " req_ready"}, {28'd0, bus.req_ready}, {28'd0, exp_ready});
        @(posedge clk);
        #1;
        check({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, exp_v});
        check({tag, " rsp_sum"}, bus.rsp_sum, exp_sum);
        check({tag, " rsp_cout"}, {31'd0, bus.rsp_cout}, {31'd0, exp_cout});
        check({tag, " rsp_id"}, {30'd0, bus.rsp_id}, {30'd0, exp_id});
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'd0, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 32'd1, 32'd2, 4'b0000, 1'b1, 4'b0010, 1'b1, 32'd3, 1'b0, 2'd1};
        vecs[2]  = '{4'b1111, 32'd10, 32'd20, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'd31, 1'b0, 2'd2};
        vecs[3]  = '{4'b0011, 32'd100, 32'd1, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'd101, 1'b0, 2'd0};
        vecs[4]  = '{4'b0000, 32'd0, 32'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'd101, 1'b0, 2'd0};
        vecs[5]  = '{4'b1000, 32'd5, 32'd7, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'd13, 1'b0, 2'd3};
        vecs[6]  = '{4'b1111, 32'd0, 32'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'd13, 1'b0, 2'd3};
        vecs[7]  = '{4'b1111, 32'd0, 32'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'd13, 1'b0, 2'd3};
        vecs[8]  = '{4'b1111, 32'd0, 32'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'd13, 1'b0, 2'd3};
        vecs[9]  = '{4'b1111, 32'h8000_0000, 32'h8000_0000, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'd0, 1'b1, 2'd0};
        vecs[10] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'hFFFF_FFFF, 1'b1, 2'd1};
        vecs[11] = '{4'b0000, 32'd0, 32'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 2'd1};
        vecs[12] = '{4'b0000, 32'd0, 32'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 2'd1};
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(4'b1111, 32'd0, 32'd0, 4'b0000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {28'd0, bus.req_ready}, 32'd0);
        check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset rsp_sum", bus.rsp_sum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].cin, 4'b0000);
            bus.rsp_ready = vecs[i].rr;
            step($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_v,
                 vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_id);
        end
        // Fairness: pointer sits at 2 after the table
        for (int k = 0; k < 4; k++) counts[k] = 0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            drive(4'b1111, k, 32'd0, 4'b0000, 4'b0000);
            step($sformatf("fair%0d", k), 4'b0001 << ((2 + k) % 4), 1'b1, k, 1'b0, 2'((2 + k) % 4));
            counts[bus.rsp_id]++;
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("fair count%0d", k), counts[k], 32'd25);
        // Lock: requester 2 chains two beats while requester 1 waits; pointer at 2
        drive(4'b0110, 32'd0, 32'd0, 4'b0100, 4'b0100);
        slot(1, 32'd1, 32'd1);
        slot(2, 32'hFFFF_FFFF, 32'd0);
        step("lock beat1", 4'b0100, 1'b1, 32'd0, 1'b1, 2'd2);
        slot(2, 32'd0, 32'd0);
        bus.req_cin  = 4'b0000;
        bus.req_lock = 4'b0000;
`ifdef FA32_ARB_LOCK_EN
        step("lock beat2", 4'b0100, 1'b1, 32'd1, 1'b0, 2'd2);
        bus.req_valid = 4'b0010;
        step("lock after", 4'b0010, 1'b1, 32'd2, 1'b0, 2'd1);
`else
        step("nolock rotate", 4'b0010, 1'b1, 32'd2, 1'b0, 2'd1);
        step("nolock beat2", 4'b0100, 1'b1, 32'd0, 1'b0, 2'd2);
`endif
        // Reset while locked on requester 3
        drive(4'b1000, 32'hFFFF_FFFF, 32'd0, 4'b1000, 4'b1000);
        step("lock3 beat1", 4'b1000, 1'b1, 32'd0, 1'b1, 2'd3);
        rst = 1'b1;
        drive(4'b1111, 32'd0, 32'd0, 4'b0000, 4'b0000);
        #1;
        check("midlock rst req_ready", {28'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("midlock rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midlock rst rsp_cout", {31'd0, bus.rsp_cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("after rst", 4'b0001, 1'b1, 32'd0, 1'b0, 2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
